// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the two-producer FIFO write arbiter.
// Holds the arbiter state encoding, the FIFO geometry constants and the
// legal range of the burst-length parameter.
package fifo_pkg;

    // Arbiter state encoding (kept as plain 2-bit constants for legacy tools)
    typedef logic [1:0] arb_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    // FIFO geometry the arbiter is built against
    localparam int FIFO_DW    = 16;
    localparam int FIFO_DEPTH = 8;

    // Legal burst lengths; the burst counter is 4 bits wide
    localparam int BURST_MIN = 1;
    localparam int BURST_LIM = 15;
    localparam int CNT_W     = 4;

    // True when a requested burst length fits the counter
    function automatic bit burst_legal(input int burst);
        return (burst >= BURST_MIN) && (burst <= BURST_LIM);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the two capture-side producers, the FIFO write
// port and the arbiter. The arbiter connects through the slave modport; the
// producers/FIFO side (or a bench) drives through the master modport.
// Optional macro: ARB_STATS_EN adds WCNT0/WCNT1/STALL statistics signals.
interface fifo_wr_arbiter_if #(
    parameter int DW = 16
);

    logic          REQ0;
    logic [DW-1:0] DIN0;
    logic          LAST0;
    logic          ACK0;

    logic          REQ1;
    logic [DW-1:0] DIN1;
    logic          LAST1;
    logic          ACK1;

    logic          FIFO_FULL;
    logic          FIFO_AFULL;
    logic          FIFO_WR;
    logic [DW-1:0] FIFO_DIN;

    logic          OWNER;
    logic          BUSY;

`ifdef ARB_STATS_EN
    logic [15:0]   WCNT0;
    logic [15:0]   WCNT1;
    logic          STALL;
`endif

    modport master (
        output REQ0, DIN0, LAST0,
        output REQ1, DIN1, LAST1,
        output FIFO_FULL, FIFO_AFULL,
        input  ACK0, ACK1,
        input  FIFO_WR, FIFO_DIN,
`ifdef ARB_STATS_EN
        input  WCNT0, WCNT1, STALL,
`endif
        input  OWNER, BUSY
    );

    modport slave (
        input  REQ0, DIN0, LAST0,
        input  REQ1, DIN1, LAST1,
        input  FIFO_FULL, FIFO_AFULL,
        output ACK0, ACK1,
        output FIFO_WR, FIFO_DIN,
`ifdef ARB_STATS_EN
        output WCNT0, WCNT1, STALL,
`endif
        output OWNER, BUSY
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Two-way round-robin selector used when the arbiter leaves IDLE.
// With both requests pending the side that did not own the FIFO last wins;
// with a single request that side wins regardless of history.
import fifo_pkg::*;

module fifo_rr_pick (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       grant,
    output logic       valid
);

    // Pure combinational pick; no state of its own
    always_comb begin
        valid = |req;
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_owner;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Two-producer write arbiter in front of the 16-bit, 8-entry FIFO.
// One producer at a time owns the FIFO write port for a burst of up to
// BURST_MAX words; ownership rotates round-robin between bursts. Write
// strobe and data are registered, and FULL/almostFULL throttle the grant so
// the FIFO never overflows.
// Optional macro: ARB_STATS_EN adds per-producer word counters (WCNT0/WCNT1)
// and a registered back-pressure indicator (STALL).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; pick the next producer (round-robin), no ACK issued
// OWN0  | producer 0 owns the FIFO write port, one word per cycle
// OWN1  | producer 1 owns the FIFO write port, one word per cycle
import fifo_pkg::*;

module fifo_wr_arbiter #(
    parameter int BURST_MAX = 4,
    parameter int DW        = FIFO_DW
) (
    input  logic             CLK,
    input  logic             RST,
    fifo_wr_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             owner;
    logic             owner_nxt;
    logic [CNT_W-1:0] cnt;
    logic             fifo_wr;
    logic [DW-1:0]    fifo_din;

    logic             perm;
    logic             ack0;
    logic             ack1;
    logic             ack_any;
    logic             own_req;
    logic             own_last;
    logic             other_req;
    logic             burst_end;
    logic             exit_own;
    logic             pick_grant;
    logic             pick_valid;

    // The FIFO flags lag our write by a cycle, so almostFULL with a write
    // already in flight must be treated as full.
    always_comb begin
        perm = !bus.FIFO_FULL && !(bus.FIFO_AFULL && fifo_wr);
    end

    // Acknowledge and burst-end decode for the current owner
    always_comb begin
        ack0      = (state == ST_OWN0) && bus.REQ0 && perm;
        ack1      = (state == ST_OWN1) && bus.REQ1 && perm;
        ack_any   = ack0 || ack1;
        own_req   = 1'b0;
        own_last  = 1'b0;
        other_req = 1'b0;
        case (state)
            ST_OWN0: begin
                own_req   = bus.REQ0;
                own_last  = bus.LAST0;
                other_req = bus.REQ1;
            end
            ST_OWN1: begin
                own_req   = bus.REQ1;
                own_last  = bus.LAST1;
                other_req = bus.REQ0;
            end
            default: begin
                own_req   = 1'b0;
                own_last  = 1'b0;
                other_req = 1'b0;
            end
        endcase
        burst_end = ack_any && (own_last || (cnt == CNT_LAST));
        exit_own  = (state != ST_IDLE) && (burst_end || !own_req);
    end

    fifo_rr_pick u_pick (
        .req        ({bus.REQ1, bus.REQ0}),
        .last_owner (owner),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // Next-state and next-owner selection
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nxt = pick_grant ? ST_OWN1 : ST_OWN0;
                    owner_nxt = pick_grant;
                end
            end
            ST_OWN0: begin
                if (exit_own) begin
                    if (other_req) begin
                        state_nxt = ST_OWN1;
                        owner_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_OWN1: begin
                if (exit_own) begin
                    if (other_req) begin
                        state_nxt = ST_OWN0;
                        owner_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, owner and burst counter registers; a stall holds all three
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            owner <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            if (exit_own) begin
                cnt <= '0;
            end else if (ack_any) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Registered FIFO write port: an acknowledged word is written next cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fifo_wr  <= 1'b0;
            fifo_din <= '0;
        end else begin
            fifo_wr <= ack_any;
            if (ack0) begin
                fifo_din <= bus.DIN0;
            end else if (ack1) begin
                fifo_din <= bus.DIN1;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] wcnt0;
    logic [15:0] wcnt1;
    logic        stall;

    // Per-producer acknowledged-word counters (wrap naturally) and stall flag
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wcnt0 <= '0;
            wcnt1 <= '0;
            stall <= 1'b0;
        end else begin
            if (ack0) begin
                wcnt0 <= wcnt0 + 16'd1;
            end
            if (ack1) begin
                wcnt1 <= wcnt1 + 16'd1;
            end
            stall <= own_req && !perm;
        end
    end

    assign bus.WCNT0 = wcnt0;
    assign bus.WCNT1 = wcnt1;
    assign bus.STALL = stall;
`endif

    assign bus.ACK0     = ack0;
    assign bus.ACK1     = ack1;
    assign bus.FIFO_WR  = fifo_wr;
    assign bus.FIFO_DIN = fifo_din;
    assign bus.OWNER    = owner;
    assign bus.BUSY     = (state != ST_IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer queues feed REQ/DIN/LAST,
// an 8-entry FIFO model consumes FIFO_WR/FIFO_DIN and drives the flags.
module tb_fifo_wr_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.DW(16)) bus ();

    fifo_wr_arbiter #(.BURST_MAX(4), .DW(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] p0_q[$];
    logic        p0_l[$];
    logic [15:0] p1_q[$];
    logic        p1_l[$];
    bit          p0_en;
    bit          p1_en;

    logic [15:0] fifo_q[$];
    logic [15:0] wr_log[$];
    int          wr_cyc[$];
    int          ack0_cyc[$];
    int          ack1_cyc[$];
    int          cyc = 0;
    int          rd_req = 0;
    bit          drain;
    bit          over_seen;

    // Producer driver and FIFO model, stepping once per clock
    initial begin
        logic        a0, a1, wr, was_full;
        logic [15:0] din;
        forever begin
            @(posedge clk);
            a0 = bus.ACK0;
            a1 = bus.ACK1;
            wr = bus.FIFO_WR;
            din = bus.FIFO_DIN;
            if (a0 === 1'b1 && p0_q.size() > 0) begin
                ack0_cyc.push_back(cyc);
                void'(p0_q.pop_front());
                void'(p0_l.pop_front());
            end
            if (a1 === 1'b1 && p1_q.size() > 0) begin
                ack1_cyc.push_back(cyc);
                void'(p1_q.pop_front());
                void'(p1_l.pop_front());
            end
            was_full = (fifo_q.size() >= 8);
            if (fifo_q.size() > 0 && (drain || rd_req > 0)) begin
                void'(fifo_q.pop_front());
                if (rd_req > 0) rd_req--;
            end
            if (wr === 1'b1) begin
                if (was_full) over_seen = 1'b1;
                else fifo_q.push_back(din);
                wr_log.push_back(din);
                wr_cyc.push_back(cyc);
            end
            cyc++;
            #1;
            bus.REQ0  = p0_en && (p0_q.size() > 0);
            bus.DIN0  = (p0_q.size() > 0) ? p0_q[0] : 16'h0;
            bus.LAST0 = (p0_q.size() > 0) ? p0_l[0] : 1'b0;
            bus.REQ1  = p1_en && (p1_q.size() > 0);
            bus.DIN1  = (p1_q.size() > 0) ? p1_q[0] : 16'h0;
            bus.LAST1 = (p1_q.size() > 0) ? p1_l[0] : 1'b0;
            bus.FIFO_FULL  = (fifo_q.size() >= 8);
            bus.FIFO_AFULL = (fifo_q.size() >= 7);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_env();
        p0_q.delete(); p0_l.delete(); p1_q.delete(); p1_l.delete();
        fifo_q.delete(); wr_log.delete(); wr_cyc.delete();
        ack0_cyc.delete(); ack1_cyc.delete();
        p0_en = 0; p1_en = 0; drain = 0; rd_req = 0; over_seen = 0;
        bus.REQ0 = 0; bus.REQ1 = 0; bus.LAST0 = 0; bus.LAST1 = 0;
        bus.DIN0 = 0; bus.DIN1 = 0; bus.FIFO_FULL = 0; bus.FIFO_AFULL = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_env();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        bit found;
        @(negedge clk);
        n_checks++; if (bus.FIFO_WR !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_wr: got %b want 0", bus.FIFO_WR); end
        n_checks++; if (bus.FIFO_DIN !== 16'h0) begin n_fail++; $display("FAIL rst_fifo_din: got %h want 0000", bus.FIFO_DIN); end
        n_checks++; if (bus.OWNER !== 1'b1) begin n_fail++; $display("FAIL rst_owner: got %b want 1", bus.OWNER); end
        n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.BUSY); end
        n_checks++; if (bus.ACK0 !== 1'b0 || bus.ACK1 !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b%b want 00", bus.ACK1, bus.ACK0); end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin p0_q.push_back(16'h00A1 + 16'(i)); p0_l.push_back(1'b0); end
        p0_en = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.FIFO_WR === 1'b1 && bus.REQ0 === 1'b1) found = 1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rst_midburst_timeout: got no write want write within 20 cycles"); end
        n = wr_log.size();
        rst = 1'b1;
        #1;
        n_checks++; if (bus.FIFO_WR !== 1'b0) begin n_fail++; $display("FAIL rst_async_wr: got %b want 0", bus.FIFO_WR); end
        n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b want 0", bus.BUSY); end
        n_checks++; if (bus.OWNER !== 1'b1) begin n_fail++; $display("FAIL rst_async_owner: got %b want 1", bus.OWNER); end
        n_checks++; if (bus.ACK0 !== 1'b0) begin n_fail++; $display("FAIL rst_async_ack0: got %b want 0", bus.ACK0); end
        @(posedge clk); #2;
        n_checks++; if (wr_log.size() !== n) begin n_fail++; $display("FAIL rst_no_write: got %0d writes want %0d", wr_log.size(), n); end
    endtask

    task automatic test_single_burst();
        logic [15:0] exp_w[3];
        do_reset();
        exp_w = '{16'h0001, 16'h0002, 16'h0003};
        for (int i = 0; i < 3; i++) begin p0_q.push_back(exp_w[i]); p0_l.push_back(i == 2); end
        p0_en = 1;
        repeat (12) @(negedge clk);
        n_checks++; if (ack0_cyc.size() !== 3) begin n_fail++; $display("FAIL single_ack_count: got %0d want 3", ack0_cyc.size()); end
        else begin
            n_checks++; if (ack0_cyc[2] - ack0_cyc[0] !== 2) begin n_fail++; $display("FAIL single_ack_consecutive: got span %0d want 2", ack0_cyc[2] - ack0_cyc[0]); end
        end
        n_checks++; if (wr_log.size() !== 3) begin n_fail++; $display("FAIL single_wr_count: got %0d want 3", wr_log.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++; if (wr_log[i] !== exp_w[i]) begin n_fail++; $display("FAIL single_wr_data[%0d]: got %h want %h", i, wr_log[i], exp_w[i]); end
            end
            if (ack0_cyc.size() == 3) begin
                n_checks++; if (wr_cyc[0] !== ack0_cyc[0] + 1) begin n_fail++; $display("FAIL single_wr_latency: got cycle %0d want %0d", wr_cyc[0], ack0_cyc[0] + 1); end
            end
        end
        n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy %b want 0", bus.BUSY); end
        n_checks++; if (ack1_cyc.size() !== 0) begin n_fail++; $display("FAIL single_ack1: got %0d want 0", ack1_cyc.size()); end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_w[16];
        exp_w = '{16'h10, 16'h11, 16'h12, 16'h13, 16'h20, 16'h21, 16'h22, 16'h23,
                  16'h14, 16'h15, 16'h16, 16'h17, 16'h24, 16'h25, 16'h26, 16'h27};
        do_reset();
        drain = 1;
        for (int i = 0; i < 8; i++) begin
            p0_q.push_back(16'h10 + 16'(i)); p0_l.push_back(1'b0);
            p1_q.push_back(16'h20 + 16'(i)); p1_l.push_back(1'b0);
        end
        p0_en = 1; p1_en = 1;
        repeat (30) @(negedge clk);
        n_checks++; if (wr_log.size() !== 16) begin n_fail++; $display("FAIL rr_wr_count: got %0d want 16", wr_log.size()); end
        else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++; if (wr_log[i] !== exp_w[i]) begin n_fail++; $display("FAIL rr_order[%0d]: got %h want %h", i, wr_log[i], exp_w[i]); end
            end
            n_checks++; if (wr_cyc[15] - wr_cyc[0] !== 15) begin n_fail++; $display("FAIL rr_no_bubble: got span %0d want 15", wr_cyc[15] - wr_cyc[0]); end
        end
        n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rr_idle: got busy %b want 0", bus.BUSY); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 10; i++) begin p0_q.push_back(16'h31 + 16'(i)); p0_l.push_back(i == 9); end
        p0_en = 1;
        repeat (25) @(negedge clk);
        n_checks++; if (wr_log.size() !== 8) begin n_fail++; $display("FAIL bp_accepted: got %0d want 8", wr_log.size()); end
        n_checks++; if (bus.ACK0 !== 1'b0) begin n_fail++; $display("FAIL bp_ack_stopped: got %b want 0", bus.ACK0); end
        n_checks++; if (bus.FIFO_WR !== 1'b0) begin n_fail++; $display("FAIL bp_wr_low: got %b want 0", bus.FIFO_WR); end
        n_checks++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL bp_held: got busy %b want 1", bus.BUSY); end
        rd_req = 2;
        repeat (12) @(negedge clk);
        n_checks++; if (wr_log.size() !== 10) begin n_fail++; $display("FAIL bp_resume: got %0d writes want 10", wr_log.size()); end
        else begin
            n_checks++; if (wr_log[8] !== 16'h39 || wr_log[9] !== 16'h3A) begin n_fail++; $display("FAIL bp_tail: got %h %h want 0039 003a", wr_log[8], wr_log[9]); end
        end
        n_checks++; if (fifo_q.size() !== 8 || fifo_q[0] !== 16'h33) begin n_fail++; $display("FAIL bp_fifo: got size %0d head %h want 8 0033", fifo_q.size(), (fifo_q.size() > 0) ? fifo_q[0] : 16'hx); end
        n_checks++; if (over_seen !== 1'b0) begin n_fail++; $display("FAIL bp_over: got %b want 0", over_seen); end
        n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got busy %b want 0", bus.BUSY); end
    endtask

    task automatic test_req_drop();
        logic [15:0] exp_w[5];
        bit found, bubble;
        exp_w = '{16'h51, 16'h52, 16'h61, 16'h62, 16'h63};
        do_reset();
        drain = 1;
        p1_q.push_back(16'h51); p1_l.push_back(1'b0);
        p1_q.push_back(16'h52); p1_l.push_back(1'b0);
        for (int i = 0; i < 3; i++) begin p0_q.push_back(16'h61 + 16'(i)); p0_l.push_back(i == 2); end
        p1_en = 1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (ack1_cyc.size() >= 1) found = 1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL drop_timeout: got no ACK1 want ACK1 within 10 cycles"); end
        p0_en = 1;
        bubble = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.BUSY !== 1'b1) bubble = 1;
        end
        repeat (8) @(negedge clk);
        n_checks++; if (bubble !== 1'b0) begin n_fail++; $display("FAIL drop_no_bubble: got idle cycle want none"); end
        n_checks++; if (ack1_cyc.size() !== 2) begin n_fail++; $display("FAIL drop_ack1_count: got %0d want 2", ack1_cyc.size()); end
        n_checks++; if (ack0_cyc.size() !== 3) begin n_fail++; $display("FAIL drop_ack0_count: got %0d want 3", ack0_cyc.size()); end
        else if (ack1_cyc.size() == 2) begin
            n_checks++; if (ack0_cyc[0] - ack1_cyc[1] !== 2) begin n_fail++; $display("FAIL drop_switch_gap: got %0d want 2", ack0_cyc[0] - ack1_cyc[1]); end
        end
        n_checks++; if (wr_log.size() !== 5) begin n_fail++; $display("FAIL drop_wr_count: got %0d want 5", wr_log.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++; if (wr_log[i] !== exp_w[i]) begin n_fail++; $display("FAIL drop_order[%0d]: got %h want %h", i, wr_log[i], exp_w[i]); end
            end
        end
        n_checks++; if (bus.OWNER !== 1'b0) begin n_fail++; $display("FAIL drop_owner: got %b want 0", bus.OWNER); end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        n_checks++; if (bus.WCNT0 !== 16'd0 || bus.WCNT1 !== 16'd0) begin n_fail++; $display("FAIL stats_reset: got %0d %0d want 0 0", bus.WCNT0, bus.WCNT1); end
        drain = 1;
        for (int i = 0; i < 20; i++) begin p1_q.push_back(16'h700 + 16'(i)); p1_l.push_back(1'b0); end
        p1_en = 1;
        repeat (40) @(negedge clk);
        n_checks++; if (bus.WCNT1 !== 16'd20) begin n_fail++; $display("FAIL stats_wcnt1: got %0d want 20", bus.WCNT1); end
        n_checks++; if (bus.WCNT0 !== 16'd0) begin n_fail++; $display("FAIL stats_wcnt0_idle: got %0d want 0", bus.WCNT0); end
        n_checks++; if (bus.STALL !== 1'b0) begin n_fail++; $display("FAIL stats_no_stall: got %b want 0", bus.STALL); end
        drain = 0;
        for (int i = 0; i < 12; i++) begin p0_q.push_back(16'h800 + 16'(i)); p0_l.push_back(1'b0); end
        p0_en = 1;
        repeat (30) @(negedge clk);
        n_checks++; if (bus.WCNT0 !== 16'd8) begin n_fail++; $display("FAIL stats_wcnt0: got %0d want 8", bus.WCNT0); end
        n_checks++; if (bus.STALL !== 1'b1) begin n_fail++; $display("FAIL stats_stall: got %b want 1", bus.STALL); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        clear_env();
        test_reset();
        test_single_burst();
        test_round_robin();
        test_backpressure();
        test_req_drop();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
